rvfi_check_sequencer: RTL and testbench
=======================================

Name: rvfi_check_sequencer

Overview:
- Drives the trig/check/core-reset stimulus for one RVFI formal check instance (liveness, order, causal, etc.).
- Holds the core in reset, counts retirements on one RVFI channel, and pulses trig on the Nth valid, non-halting retirement.
- Pulses check a fixed number of cycles after trig, then reports done.
- Sits between the testbench top and the check module, replacing per-harness ad-hoc cycle counters; a timeout flags runs that never reach the trigger.

Parameters:
- NRET, 1, number of RVFI retirement channels (matches RISCV_FORMAL_NRET).
- CHANNEL_IDX, 0, channel whose retirements are counted and trigger trig (0..NRET-1).
- CNT_W, 16, width of all internal counters.
- RESET_CYCLES, 1, cycles core_reset is held high after start (>=1).
- TRIG_INSN, 1, trig fires on the TRIG_INSN-th qualifying retirement (>=1).
- CHECK_DELAY, 10, cycles from the trig cycle to the check cycle (>=1).
- TRIG_TIMEOUT, 1000, cycles in RUN without trig before abort (>=1).

Ports:
- clock  in  1  sole clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset: 0 resets all state immediately; released synchronously by the environment.
- start  in  1  begin a sequence; honoured only in IDLE or DONE.
- rvfi_valid  in  NRET  per-channel retirement valid.
- rvfi_halt  in  NRET  per-channel halt flag.
- core_reset  out  1  active-high reset to the core and check module.
- trig  out  1  one-cycle trigger to the check module (combinational from rvfi inputs in RUN).
- check  out  1  one-cycle, registered check strobe.
- busy  out  1  high in RST, RUN and WAIT.
- done  out  1  high in DONE.
- timeout  out  1  sticky; set when RUN aborts; cleared on start or reset.

Behaviour:
- States: IDLE, RST, RUN, WAIT, DONE. Reset state is IDLE.
- Reset values: all outputs 0; all counters 0.
- IDLE:
  - start=1 moves to RST and loads cyc_cnt=0.
  - core_reset=1 in the first cycle after the start cycle.
- RST:
  - core_reset=1.
  - cyc_cnt increments each cycle.
  - When cyc_cnt==RESET_CYCLES-1, go to RUN and clear ret_cnt and cyc_cnt.
  - core_reset is high for exactly RESET_CYCLES cycles.
- RUN:
  - core_reset=0.
  - Define qual = rvfi_valid[CHANNEL_IDX] & ~rvfi_halt[CHANNEL_IDX].
  - trig = qual & (ret_cnt==TRIG_INSN-1), driven in the same cycle as the retirement. The check module then sees rvfi_valid high and halt low at trig.
  - If qual=1 and trig=0, ret_cnt increments.
  - If trig=1, go to WAIT with dly_cnt=1.
  - Otherwise cyc_cnt increments. When cyc_cnt==TRIG_TIMEOUT-1 with no trig, go to DONE and set timeout=1; check never fires.
  - If trig and timeout occur in the same cycle, trig wins.
  - Valid on other channels and halting retirements are ignored.
- WAIT:
  - check is registered: check=1 in the cycle where dly_cnt==CHECK_DELAY, counting from the trig cycle = 0. That cycle is trig cycle + CHECK_DELAY.
  - After the check cycle, go to DONE.
  - rvfi inputs are ignored. trig is never re-asserted in a sequence.
- DONE:
  - done=1.
  - start=1 re-enters RST with timeout cleared.
- start is ignored while busy. start and reset low together: reset wins.
- Reset mid-sequence (any state): asynchronous return to IDLE; core_reset, trig and check drop in the same instant; timeout is cleared.
- Counters saturate at 2^CNT_W-1. Parameters exceeding the counter width are an elaboration error (generate-time check).
- trig and check are never high in the same cycle (CHECK_DELAY>=1).

Test Plan:
- Defaults; start at cycle 5; rvfi_valid[0]=1 every cycle from cycle 7 -> core_reset high cycle 6 only; trig high cycle 7; check high cycle 17; done from cycle 18.
- TRIG_INSN=3, RESET_CYCLES=4; valid on cycles 12,14,15,20 with halt=1 at 14 -> ret_cnt counts 12,15; trig at cycle 20; check at 30.
- NRET=2, CHANNEL_IDX=1; valid only on channel 0 for 50 cycles, then channel 1 -> no trig until channel 1 valid; trig in that exact cycle.
- TRIG_TIMEOUT=20; no rvfi_valid after start -> DONE with timeout=1 20 cycles after RUN entry; check never asserted; restart with start clears timeout.
- reset low during WAIT, 3 cycles after trig -> all outputs 0 immediately; IDLE after release; start then replays a full sequence normally.
- start pulsed during RUN and WAIT -> ignored; sequence timing unchanged; start in DONE -> core_reset the next cycle.

Source files
------------

// File: rtl/rvfi_check_sequencer.sv
// Sequences core reset, trig and check strobes for one RVFI formal check instance.
// Counts qualifying retirements on one channel, fires trig on the Nth, check a fixed delay later.
module rvfi_check_sequencer #(
    parameter int NRET         = 1,
    parameter int CHANNEL_IDX  = 0,
    parameter int CNT_W        = 16,
    parameter int RESET_CYCLES = 1,
    parameter int TRIG_INSN    = 1,
    parameter int CHECK_DELAY  = 10,
    parameter int TRIG_TIMEOUT = 1000
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [NRET-1:0] rvfi_valid,
    input  logic [NRET-1:0] rvfi_halt,
    output logic            core_reset,
    output logic            trig,
    output logic            check,
    output logic            busy,
    output logic            done,
    output logic            timeout
);

    localparam longint unsigned CNT_LIMIT = (64'd1 << CNT_W) - 64'd1;

    if (RESET_CYCLES < 1 || TRIG_INSN < 1 || CHECK_DELAY < 1 || TRIG_TIMEOUT < 1) begin : g_bad_min
        $error("rvfi_check_sequencer: cycle/count parameters must be >= 1");
    end
    if (CHANNEL_IDX < 0 || CHANNEL_IDX >= NRET) begin : g_bad_chan
        $error("rvfi_check_sequencer: CHANNEL_IDX out of range");
    end
    if (64'(RESET_CYCLES) > CNT_LIMIT || 64'(TRIG_INSN) > CNT_LIMIT ||
        64'(CHECK_DELAY) > CNT_LIMIT || 64'(TRIG_TIMEOUT) > CNT_LIMIT) begin : g_bad_width
        $error("rvfi_check_sequencer: parameter exceeds counter width");
    end

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_INSN - 1);
    localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(CHECK_DELAY);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TRIG_TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_RST, S_RUN, S_WAIT, S_DONE} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] ret_q, ret_d;
    logic [CNT_W-1:0] dly_q, dly_d;
    logic             timeout_q, timeout_d;
    logic             check_q, check_d;
    logic             qual;
    logic             unused_inputs;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    assign qual          = rvfi_valid[CHANNEL_IDX] & ~rvfi_halt[CHANNEL_IDX];
    assign unused_inputs = ^{rvfi_valid, rvfi_halt};

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_d   = state_q;
        cyc_d     = cyc_q;
        ret_d     = ret_q;
        dly_d     = dly_q;
        timeout_d = timeout_q;
        trig      = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_RST;
                    cyc_d     = '0;
                    timeout_d = 1'b0;
                end
            end
            S_RST: begin
                if (cyc_q == RST_LAST) begin
                    state_d = S_RUN;
                    cyc_d   = '0;
                    ret_d   = '0;
                end else begin
                    cyc_d = sat_inc(cyc_q);
                end
            end
            S_RUN: begin
                // trig is combinational so it coincides with the retirement the check module samples.
                trig = qual && (ret_q == TRIG_LAST);
                if (trig) begin
                    state_d = S_WAIT;
                    dly_d   = CNT_W'(1);
                end else begin
                    if (qual) ret_d = sat_inc(ret_q);
                    if (cyc_q == TO_LAST) begin
                        state_d   = S_DONE;
                        timeout_d = 1'b1;
                    end else begin
                        cyc_d = sat_inc(cyc_q);
                    end
                end
            end
            S_WAIT: begin
                if (dly_q == DLY_LAST) state_d = S_DONE;
                else                   dly_d   = sat_inc(dly_q);
            end
            default: state_d = S_IDLE;
        endcase
        check_d = (state_d == S_WAIT) && (dly_d == DLY_LAST);
    end

    // NOTE: state registers use non-blocking assignments so all flops update from the same pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cyc_q     <= '0;
            ret_q     <= '0;
            dly_q     <= '0;
            timeout_q <= 1'b0;
            check_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            ret_q     <= ret_d;
            dly_q     <= dly_d;
            timeout_q <= timeout_d;
            check_q   <= check_d;
        end
    end

    assign core_reset = (state_q == S_RST);
    assign busy       = (state_q == S_RST) || (state_q == S_RUN) || (state_q == S_WAIT);
    assign done       = (state_q == S_DONE);
    assign timeout    = timeout_q;
    assign check      = check_q;

endmodule

// File: tb/tb_rvfi_check_sequencer.sv
// Bench for rvfi_check_sequencer: four parameterisations driven together, checked
// every cycle against a timeline model plus directed event-cycle checks.
module tb_rvfi_check_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [3:0] st;
    logic [1:0] vld [4];
    logic [1:0] hlt [4];
    logic [3:0] cr, tg, ck, bz, dn, tmo;

    int total = 0;
    int bad   = 0;
    int c     = 0;

    // Per-instance parameters as seen by the model.
    int p_rc [4] = '{1, 4, 1, 1};
    int p_ti [4] = '{1, 3, 1, 1};
    int p_cd [4] = '{10, 10, 10, 10};
    int p_to [4] = '{1000, 1000, 1000, 20};
    int p_ch [4] = '{0, 0, 1, 0};

    // Timeline model: start cycle, trig cycle, first DONE cycle, first timeout cycle.
    bit seq    [4];
    int s      [4];
    int trig_c [4];
    int end_c  [4];
    int tmo_c  [4];
    int nq     [4];

    int obs_trig [4];
    int obs_chk  [4];
    int obs_to   [4];

    rvfi_check_sequencer u0 (
        .clock(clk), .reset(rst_n), .start(st[0]),
        .rvfi_valid(vld[0][0:0]), .rvfi_halt(hlt[0][0:0]),
        .core_reset(cr[0]), .trig(tg[0]), .check(ck[0]),
        .busy(bz[0]), .done(dn[0]), .timeout(tmo[0])
    );

    rvfi_check_sequencer #(.RESET_CYCLES(4), .TRIG_INSN(3)) u1 (
        .clock(clk), .reset(rst_n), .start(st[1]),
        .rvfi_valid(vld[1][0:0]), .rvfi_halt(hlt[1][0:0]),
        .core_reset(cr[1]), .trig(tg[1]), .check(ck[1]),
        .busy(bz[1]), .done(dn[1]), .timeout(tmo[1])
    );

    rvfi_check_sequencer #(.NRET(2), .CHANNEL_IDX(1)) u2 (
        .clock(clk), .reset(rst_n), .start(st[2]),
        .rvfi_valid(vld[2]), .rvfi_halt(hlt[2]),
        .core_reset(cr[2]), .trig(tg[2]), .check(ck[2]),
        .busy(bz[2]), .done(dn[2]), .timeout(tmo[2])
    );

    rvfi_check_sequencer #(.TRIG_TIMEOUT(20)) u3 (
        .clock(clk), .reset(rst_n), .start(st[3]),
        .rvfi_valid(vld[3][0:0]), .rvfi_halt(hlt[3][0:0]),
        .core_reset(cr[3]), .trig(tg[3]), .check(ck[3]),
        .busy(bz[3]), .done(dn[3]), .timeout(tmo[3])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, c, obs, exp);
        end
    endtask

    task automatic clear_obs();
        for (int i = 0; i < 4; i++) begin
            obs_trig[i] = -1;
            obs_chk[i]  = -1;
            obs_to[i]   = -1;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            seq[i] = 1'b0; s[i] = 0; trig_c[i] = -1; end_c[i] = -1; tmo_c[i] = -1; nq[i] = 0;
        end
    endtask

    // Compare one cycle at the falling edge, then advance to just after the next rising edge.
    task automatic tick();
        logic e_cr, e_tg, e_ck, e_bz, e_dn, e_to, q, in_run;
        int   run0;
        @(negedge clk);
        if (!rst_n) model_reset();
        for (int i = 0; i < 4; i++) begin
            e_cr = 1'b0; e_tg = 1'b0; e_ck = 1'b0; e_bz = 1'b0; e_dn = 1'b0; e_to = 1'b0;
            if (rst_n) begin
                q      = vld[i][p_ch[i]] & ~hlt[i][p_ch[i]];
                run0   = s[i] + p_rc[i] + 1;
                in_run = seq[i] && c >= run0 && trig_c[i] < 0 && end_c[i] < 0;
                e_cr   = seq[i] && c > s[i] && c <= s[i] + p_rc[i];
                if (in_run && q && nq[i] == p_ti[i] - 1) begin
                    e_tg      = 1'b1;
                    trig_c[i] = c;
                    end_c[i]  = c + p_cd[i] + 1;
                end else if (in_run) begin
                    if (q) nq[i]++;
                    if (c == run0 + p_to[i] - 1) begin
                        end_c[i] = c + 1;
                        tmo_c[i] = c + 1;
                    end
                end
                e_ck = trig_c[i] >= 0 && c == trig_c[i] + p_cd[i];
                e_dn = end_c[i] >= 0 && c >= end_c[i];
                e_bz = seq[i] && c > s[i] && !e_dn;
                e_to = tmo_c[i] >= 0 && c >= tmo_c[i];
            end
            check($sformatf("u%0d_core_reset", i), cr[i],  e_cr);
            check($sformatf("u%0d_trig", i),       tg[i],  e_tg);
            check($sformatf("u%0d_check", i),      ck[i],  e_ck);
            check($sformatf("u%0d_busy", i),       bz[i],  e_bz);
            check($sformatf("u%0d_done", i),       dn[i],  e_dn);
            check($sformatf("u%0d_timeout", i),    tmo[i], e_to);
            if (tg[i] === 1'b1 && obs_trig[i] < 0) obs_trig[i] = c;
            if (ck[i] === 1'b1 && obs_chk[i] < 0)  obs_chk[i]  = c;
            if (tmo[i] === 1'b1 && obs_to[i] < 0)  obs_to[i]   = c;
            if (rst_n && st[i] && !e_bz) begin
                seq[i] = 1'b1; s[i] = c; trig_c[i] = -1; end_c[i] = -1; tmo_c[i] = -1; nq[i] = 0;
            end
        end
        @(posedge clk);
        #1;
        c++;
    endtask

    initial begin
        rst_n = 1'b0;
        st    = '0;
        for (int i = 0; i < 4; i++) begin
            vld[i] = '0;
            hlt[i] = '0;
        end
        model_reset();
        clear_obs();
        @(posedge clk);
        #1;

        // Reset state, with start held high to show reset dominates.
        st = 4'hf;
        repeat (3) tick();
        st    = '0;
        rst_n = 1'b1;
        c     = 0;

        // Directed plan: all four instances started at cycle 5.
        for (int k = 0; k < 80; k++) begin
            st    = {4{c == 5}};
            st[0] = st[0] | (c == 9) | (c == 12);
            st[2] = st[2] | (c == 30);
            vld[0] = {1'b0, c >= 7};
            hlt[0] = '0;
            vld[1] = {1'b0, (c == 12) || (c == 14) || (c == 15) || (c == 20)};
            hlt[1] = {1'b0, c == 14};
            vld[2] = {c == 57, c >= 7 && c < 57};
            hlt[2] = '0;
            vld[3] = '0;
            hlt[3] = '0;
            tick();
        end
        check("u0_trig_cycle",  obs_trig[0], 7);
        check("u0_check_cycle", obs_chk[0],  17);
        check("u1_trig_cycle",  obs_trig[1], 20);
        check("u1_check_cycle", obs_chk[1],  30);
        check("u2_trig_cycle",  obs_trig[2], 57);
        check("u2_check_cycle", obs_chk[2],  67);
        check("u3_trig_cycle",  obs_trig[3], -1);
        check("u3_check_cycle", obs_chk[3],  -1);
        check("u3_timeout_cycle", obs_to[3], 27);

        // Restart from DONE, reset in WAIT three cycles after trig, then replay.
        for (int k = 0; k < 60; k++) begin
            st     = {4{(c == 80) || (c == 89)}};
            vld[0] = 2'b01;
            vld[1] = 2'b01;
            vld[2] = 2'b10;
            vld[3] = 2'b00;
            for (int i = 0; i < 4; i++) hlt[i] = '0;
            if (c == 85) begin
                rst_n = 1'b0;
                #1;
                for (int i = 0; i < 4; i++) begin
                    check($sformatf("u%0d_async_core_reset", i), cr[i],  1'b0);
                    check($sformatf("u%0d_async_trig", i),       tg[i],  1'b0);
                    check($sformatf("u%0d_async_check", i),      ck[i],  1'b0);
                    check($sformatf("u%0d_async_busy", i),       bz[i],  1'b0);
                    check($sformatf("u%0d_async_timeout", i),    tmo[i], 1'b0);
                end
            end
            if (c == 87) begin
                rst_n = 1'b1;
                clear_obs();
            end
            tick();
        end
        check("u0_replay_trig",  obs_trig[0], 91);
        check("u0_replay_check", obs_chk[0],  101);
        check("u1_replay_trig",  obs_trig[1], 96);
        check("u1_replay_check", obs_chk[1],  106);
        check("u2_replay_trig",  obs_trig[2], 91);
        check("u3_replay_timeout", obs_to[3], 111);

        // Randomized traffic against the model.
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < 4; i++) begin
                st[i]  = ($urandom_range(0, 11) == 0);
                vld[i] = 2'($urandom_range(0, 3));
                hlt[i] = {$urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0};
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
